cluster_hub_switch: RTL
=======================

# cluster_hub_switch

Parametrised successor to the fixed 4-leaf cluster hub. Concentrates NUM_LEAVES leaf uplinks onto one superhub uplink with round-robin arbitration and per-leaf ingress FIFOs. Demultiplexes superhub downlink traffic to the leaves. Optionally switches intra-cluster traffic leaf-to-leaf without a superhub round trip (LOCAL_BYPASS). Sits between a cluster's leaf nodes and the superhub, one instance per cluster.

## Interface
- NUM_LEAVES, 4: leaf count; power of 2, range 2..16
- FLIT_W, 20: flit width
- CL_W, 2: cluster-ID width
- LOC_W, log2(NUM_LEAVES): local-ID width (derived)
- FIFO_DEPTH, 4: ingress FIFO entries per leaf; power of 2, at least 2
- LOCAL_BYPASS, 1: 1 = intra-cluster flits go leaf-to-leaf; 0 = every flit goes to superhub
- Flit format: [FLIT_W-1 -: CL_W] = dst cluster; next LOC_W bits = dst local; remaining bits = payload, carried unmodified

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- my_cluster  in  CL_W  this cluster's ID; static
- leaf_up_data  in  NUM_LEAVES*FLIT_W  leaf i occupies slice [i*FLIT_W +: FLIT_W]
- leaf_up_valid  in  NUM_LEAVES  per-leaf flit valid
- leaf_up_ready  out  NUM_LEAVES  per-leaf ingress FIFO not full
- sh_up_data  out  FLIT_W  flit to superhub
- sh_up_valid  out  1  flit to superhub valid
- sh_up_ready  in  1  superhub accepts
- sh_dn_data  in  FLIT_W  flit from superhub
- sh_dn_valid  in  1  flit from superhub valid
- sh_dn_ready  out  1  hub accepts the superhub flit
- leaf_dn_data  out  NUM_LEAVES*FLIT_W  per-leaf egress flit
- leaf_dn_valid  out  NUM_LEAVES  per-leaf egress valid
- leaf_dn_ready  in  NUM_LEAVES  per-leaf egress accept

## Operation
- Handshake (all links): a transfer occurs on a rising edge where valid && ready.
  - A valid flit holds its data stable until transferred.
- Ingress:
  - One FIFO per leaf; push on leaf_up_valid[i] && leaf_up_ready[i].
  - leaf_up_ready[i] = !full, derived from registered state only.
  - Pop at most one flit per FIFO per cycle.
- Classification of FIFO heads:
  - local = (LOCAL_BYPASS==1 && dst cluster == my_cluster).
  - All other heads are uplink heads.
- Uplink arbiter:
  - Round-robin over leaves with a non-empty FIFO and an uplink head.
  - Search starts at pointer up_ptr.
  - Grant only when the sh_up output register is empty or draining this cycle.
  - On a grant to leaf g: pop FIFO g, load the register, set up_ptr = g+1 mod NUM_LEAVES.
- Local arbiter:
  - Independent round-robin pointer lb_ptr over local heads.
  - Selects at most one flit per cycle.
  - Grant only if the destination leaf's egress register can load and the flit wins any conflict.
- Downlink:
  - Superhub flit is routed by dst local; dst cluster is ignored.
  - sh_dn_ready is combinational: destination egress register empty or draining, and the superhub wins any conflict.
  - sh_dn_ready depends combinationally on sh_dn_data.
- Conflict (superhub flit and local flit target the same leaf in one cycle):
  - Global bit prio decides: 0 = superhub wins, 1 = local wins.
  - prio toggles after every conflict.
  - The loser stays put, with no pop and no accept.
- A local flit whose dst local equals its source leaf is delivered to that leaf.
- Egress registers:
  - One per leaf, 1 entry each.
  - Load in the same cycle as the drain is allowed (full throughput).

## Timing
- Reset, applied asynchronously:
  - All FIFOs empty.
  - sh_up_valid = 0, sh_up_data = 0.
  - leaf_dn_valid = 0, leaf_dn_data = 0.
  - up_ptr = lb_ptr = 0, prio = 0.
  - leaf_up_ready = 0 while rst is high; all ones on the first cycle after release.
  - sh_dn_ready = 0 while rst is high.
- Reset asserted mid-transfer discards all buffered flits; no partial output.
- Latency:
  - Leaf push at edge T -> sh_up_valid at T+2 (empty path, ready high).
  - Superhub accept at T -> leaf_dn_valid at T+1.
  - Local bypass push at T -> leaf_dn_valid at T+2.
- Throughput: 1 flit/cycle on the uplink and on each leaf egress.
  - Simultaneous uplink and local grants from different leaves are allowed in the same cycle.
- Full FIFO with push and pop in the same cycle:
  - Ready is already 0, so no push.
  - Ready rises the cycle after the pop.
- Empty FIFO: a push and a grant of the same flit cannot occur in one cycle (no fall-through).

## Test plan
- Reset: assert rst during 4-leaf traffic -> all valids and data 0, leaf_up_ready = 0000. Release -> leaf_up_ready = 1111, nothing emitted.
- Single uplink: my_cluster=0; leaf 2 pushes 20'h4_5A5A (dst cluster 1) at T -> sh_up_data = 20'h4_5A5A, sh_up_valid=1 at T+2, exactly one transfer.
- Fairness: all 4 leaves push off-cluster flits every cycle, sh_up_ready=1 -> output leaf order 0,1,2,3,0,1,... with no gaps after the first flit.
- Backpressure: sh_up_ready=0, leaf 0 streams -> exactly FIFO_DEPTH+1 = 5 flits accepted, then leaf_up_ready[0]=0. Raise ready -> all 5 emerge in order.
- Downlink blocking: leaf_dn_ready[3]=0; superhub sends two flits to local 3 -> first accepted, sh_dn_ready=0 on the second. Switch the second to local 1 -> accepted, leaf_dn_valid[1] next cycle.
- Conflict: leaf 0 local flit to leaf 1 and a superhub flit to leaf 1 in the same cycle -> superhub flit delivered first, local flit one cycle later. Repeat the conflict -> the local flit wins.

Source files
------------

// File: rtl/cluster_hub_switch.sv
// cluster_hub_switch: concentrates NUM_LEAVES leaf uplinks onto one superhub
// uplink, demultiplexes superhub downlink flits to the leaves, and optionally
// switches intra-cluster flits leaf-to-leaf without a superhub round trip.
module cluster_hub_switch #(
  parameter int unsigned NUM_LEAVES   = 4,
  parameter int unsigned FLIT_W       = 20,
  parameter int unsigned CL_W         = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter bit          LOCAL_BYPASS = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CL_W-1:0]              my_cluster,
  input  logic [NUM_LEAVES*FLIT_W-1:0] leaf_up_data,
  input  logic [NUM_LEAVES-1:0]        leaf_up_valid,
  output logic [NUM_LEAVES-1:0]        leaf_up_ready,
  output logic [FLIT_W-1:0]            sh_up_data,
  output logic                         sh_up_valid,
  input  logic                         sh_up_ready,
  input  logic [FLIT_W-1:0]            sh_dn_data,
  input  logic                         sh_dn_valid,
  output logic                         sh_dn_ready,
  output logic [NUM_LEAVES*FLIT_W-1:0] leaf_dn_data,
  output logic [NUM_LEAVES-1:0]        leaf_dn_valid,
  input  logic [NUM_LEAVES-1:0]        leaf_dn_ready
);

  localparam int unsigned LOC_W  = $clog2(NUM_LEAVES);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LOC_HI = FLIT_W - CL_W - 1;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [LOC_W-1:0]  leaf_t;
  typedef logic [PTR_W:0]    fptr_t;

  flit_t                 fifo_mem [NUM_LEAVES][FIFO_DEPTH];
  fptr_t                 wr_ptr   [NUM_LEAVES];
  fptr_t                 rd_ptr   [NUM_LEAVES];
  flit_t                 head     [NUM_LEAVES];
  leaf_t                 head_dst [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] fifo_empty;
  logic [NUM_LEAVES-1:0] fifo_full;
  logic [NUM_LEAVES-1:0] push;
  logic [NUM_LEAVES-1:0] pop;
  logic [NUM_LEAVES-1:0] up_req;
  logic [NUM_LEAVES-1:0] lb_req;
  logic [NUM_LEAVES-1:0] eg_can;

  leaf_t up_ptr;
  leaf_t lb_ptr;
  leaf_t up_idx;
  leaf_t lb_idx;
  leaf_t lb_tgt;
  leaf_t sh_tgt;
  logic  up_found;
  logic  up_gnt;
  logic  lb_found;
  logic  lb_gnt;
  logic  conflict;
  logic  prio;
  logic  sh_acc;

  // Ingress ready comes from registered FIFO state only, forced low in reset
  assign leaf_up_ready = rst ? '0 : ~fifo_full;

  // FIFO status, head classification and egress availability per leaf
  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      fifo_empty[i] = (wr_ptr[i] == rd_ptr[i]);
      fifo_full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                      (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
      head[i]       = fifo_mem[i][rd_ptr[i][PTR_W-1:0]];
      head_dst[i]   = head[i][LOC_HI -: LOC_W];
      push[i]       = leaf_up_valid[i] && leaf_up_ready[i];
      lb_req[i]     = !fifo_empty[i] && LOCAL_BYPASS &&
                      (head[i][FLIT_W-1 -: CL_W] == my_cluster);
      up_req[i]     = !fifo_empty[i] && !lb_req[i];
      eg_can[i]     = !leaf_dn_valid[i] || leaf_dn_ready[i];
    end
  end

  // Round-robin uplink and local arbiters, downlink conflict resolution
  always_comb begin
    leaf_t idx;
    idx      = '0;
    up_found = 1'b0;
    up_idx   = '0;
    lb_found = 1'b0;
    lb_idx   = '0;
    for (int k = 0; k < NUM_LEAVES; k++) begin
      idx = up_ptr + leaf_t'(k);
      if (!up_found && up_req[idx]) begin
        up_found = 1'b1;
        up_idx   = idx;
      end
      idx = lb_ptr + leaf_t'(k);
      if (!lb_found && lb_req[idx] && eg_can[head_dst[idx]]) begin
        lb_found = 1'b1;
        lb_idx   = idx;
      end
    end
    up_gnt      = up_found && (!sh_up_valid || sh_up_ready);
    lb_tgt      = head_dst[lb_idx];
    sh_tgt      = sh_dn_data[LOC_HI -: LOC_W];
    // Both contenders can only collide on an egress that is able to load
    conflict    = lb_found && sh_dn_valid && (sh_tgt == lb_tgt);
    lb_gnt      = lb_found && !(conflict && !prio);
    sh_dn_ready = !rst && eg_can[sh_tgt] && !(conflict && prio);
    sh_acc      = sh_dn_valid && sh_dn_ready;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      pop[i] = (up_gnt && (up_idx == leaf_t'(i))) ||
               (lb_gnt && (lb_idx == leaf_t'(i)));
    end
  end

  // FIFO storage, written on accepted pushes
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (push[i]) begin
        fifo_mem[i][wr_ptr[i][PTR_W-1:0]] <= leaf_up_data[i*FLIT_W +: FLIT_W];
      end
    end
  end

  // FIFO pointers; reset empties every FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEAVES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEAVES; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + fptr_t'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + fptr_t'(1);
      end
    end
  end

  // Uplink output register plus arbiter pointers and conflict priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_up_valid <= 1'b0;
      sh_up_data  <= '0;
      up_ptr      <= '0;
      lb_ptr      <= '0;
      prio        <= 1'b0;
    end else begin
      if (up_gnt) begin
        sh_up_valid <= 1'b1;
        sh_up_data  <= head[up_idx];
        up_ptr      <= up_idx + leaf_t'(1);
      end else if (sh_up_ready) begin
        sh_up_valid <= 1'b0;
      end
      if (lb_gnt)   lb_ptr <= lb_idx + leaf_t'(1);
      if (conflict) prio   <= !prio;
    end
  end

  // Per-leaf egress registers; at most one source loads each leaf per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leaf_dn_valid <= '0;
      leaf_dn_data  <= '0;
    end else begin
      for (int d = 0; d < NUM_LEAVES; d++) begin
        if (sh_acc && (sh_tgt == leaf_t'(d))) begin
          leaf_dn_valid[d]                <= 1'b1;
          leaf_dn_data[d*FLIT_W +: FLIT_W] <= sh_dn_data;
        end else if (lb_gnt && (lb_tgt == leaf_t'(d))) begin
          leaf_dn_valid[d]                <= 1'b1;
          leaf_dn_data[d*FLIT_W +: FLIT_W] <= head[lb_idx];
        end else if (leaf_dn_ready[d]) begin
          leaf_dn_valid[d] <= 1'b0;
        end
      end
    end
  end

endmodule
